// File: rtl/ahb_decoder_mux.sv
// ahb_decoder_mux
//   AHB-Lite interconnect for the Cortex-M0 SoC. Decodes the address phase
//   into NSLV one-hot slave selects and registers the data-phase owner. It
//   muxes the owner's HRDATA/HREADY/HRESP back to the core.
//
//   Unmapped NONSEQ/SEQ accesses are answered by an internal default slave
//   with a two-cycle ERROR. When TIMEOUT > 0, a slave that holds HREADYOUT
//   low for TIMEOUT cycles is abandoned with a two-cycle ERROR. A single
//   TIMEOUT_IRQ pulse accompanies that abort.
//
//   state    | meaning
//   DS_IDLE  | no default-slave transfer in data phase
//   DS_ERR1  | default slave: ERROR first cycle (HREADY=0, HRESP=1)
//   DS_ERR2  | default slave: ERROR second cycle (HREADY=1, HRESP=1)
//   TO_IDLE  | counting wait cycles of the selected slave
//   TO_ERR1  | count reached: slave completes if ready, else ERROR first cycle
//   TO_ERR2  | timeout ERROR second cycle
//
// Ports
//   HCLK, HRESETn   clock, asynchronous active-low reset
//   HADDR, HTRANS   master address phase
//   HREADY          ready to master, broadcast to slaves
//   HRDATA, HRESP   muxed read data / response to master
//   HSEL            combinational one-hot slave selects
//   HREADYOUT_S     per-slave ready
//   HRESP_S         per-slave error response
//   HRDATA_S        packed per-slave read data
//   TIMEOUT_IRQ     one-cycle pulse on a timeout abort
module ahb_decoder_mux #(
    parameter int                 NSLV      = 4,
    parameter logic [NSLV*32-1:0] ADDR_BASE = {NSLV{32'h0}},
    parameter logic [NSLV*32-1:0] ADDR_MASK = {NSLV{32'hFFFFF000}},
    parameter int                 TIMEOUT   = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [31:0]          HADDR,
    input  logic [1:0]           HTRANS,
    output logic                 HREADY,
    output logic [31:0]          HRDATA,
    output logic                 HRESP,
    output logic [NSLV-1:0]      HSEL,
    input  logic [NSLV-1:0]      HREADYOUT_S,
    input  logic [NSLV-1:0]      HRESP_S,
    input  logic [NSLV*32-1:0]   HRDATA_S,
    output logic                 TIMEOUT_IRQ
);

    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;
    typedef enum logic [1:0] {TO_IDLE, TO_ERR1, TO_ERR2} to_state_t;

    logic [NSLV-1:0] match;
    logic            found;
    logic            unmapped;
    logic [NSLV-1:0] dp_sel;
    logic            dp_def;
    logic            sel_ready;
    logic            sel_resp;
    logic [31:0]     sel_data;
    logic            to_err1;
    logic            to_err2;
    ds_state_t       ds_state, ds_next;

    // Lowest matching index wins so overlapping windows stay one-hot.
    always_comb begin
        match = '0;
        HSEL  = '0;
        found = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            match[i] = ((HADDR & ADDR_MASK[32*i +: 32]) ==
                        (ADDR_BASE[32*i +: 32] & ADDR_MASK[32*i +: 32]));
            if (match[i] && !found) begin
                HSEL[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    assign unmapped = HTRANS[1] & ~(|match);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_sel <= '0;
            dp_def <= 1'b0;
        end else if (HREADY) begin
            dp_sel <= HSEL & {NSLV{HTRANS[1]}};
            dp_def <= unmapped;
        end
    end

    always_comb begin
        sel_ready = 1'b1;
        sel_resp  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (dp_sel[i]) begin
                sel_ready = HREADYOUT_S[i];
                sel_resp  = HRESP_S[i];
                sel_data  = HRDATA_S[32*i +: 32];
            end
        end
    end

    // Default slave moves to DS_ERR1 on the same edge that loads dp_def,
    // so the ERROR starts in the first data-phase cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) ds_state <= DS_IDLE;
        else          ds_state <= ds_next;
    end

    always_comb begin
        ds_next = ds_state;
        case (ds_state)
            DS_IDLE: if (HREADY && unmapped) ds_next = DS_ERR1;
            DS_ERR1: ds_next = DS_ERR2;
            DS_ERR2: ds_next = unmapped ? DS_ERR1 : DS_IDLE;
            default: ds_next = DS_IDLE;
        endcase
    end

    generate
        if (TIMEOUT > 0) begin : g_to
            localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
            logic [15:0] wait_cnt;
            logic        slave_wait;
            to_state_t   to_state, to_next;

            assign slave_wait = (|dp_sel) & ~sel_ready;

            always_ff @(posedge HCLK or negedge HRESETn) begin
                if (!HRESETn) begin
                    to_state <= TO_IDLE;
                    wait_cnt <= '0;
                end else begin
                    to_state <= to_next;
                    if (HREADY)
                        wait_cnt <= '0;
                    else if (to_state == TO_IDLE && slave_wait)
                        wait_cnt <= wait_cnt + 16'd1;
                end
            end

            // TO_ERR1 is entered once TIMEOUT waits have elapsed; a slave
            // that is ready in that cycle still completes normally.
            always_comb begin
                to_next = to_state;
                case (to_state)
                    TO_IDLE: if (slave_wait && wait_cnt == TO_LAST) to_next = TO_ERR1;
                    TO_ERR1: to_next = sel_ready ? TO_IDLE : TO_ERR2;
                    TO_ERR2: to_next = TO_IDLE;
                    default: to_next = TO_IDLE;
                endcase
            end

            assign to_err1 = (to_state == TO_ERR1) & ~sel_ready;
            assign to_err2 = (to_state == TO_ERR2);
        end else begin : g_no_to
            assign to_err1 = 1'b0;
            assign to_err2 = 1'b0;
        end
    endgenerate

    always_comb begin
        HREADY      = sel_ready;
        HRESP       = sel_resp;
        HRDATA      = sel_data;
        TIMEOUT_IRQ = 1'b0;
        if (dp_def) begin
            HREADY = (ds_state == DS_ERR2);
            HRESP  = 1'b1;
            HRDATA = '0;
        end else if (to_err1) begin
            HREADY      = 1'b0;
            HRESP       = 1'b1;
            HRDATA      = '0;
            TIMEOUT_IRQ = 1'b1;
        end else if (to_err2) begin
            HREADY = 1'b1;
            HRESP  = 1'b1;
            HRDATA = '0;
        end
    end

endmodule

// File: tb/tb_ahb_decoder_mux.sv
module tb_ahb_decoder_mux;

    localparam logic [31:0] D0 = 32'hD000_0000;
    localparam logic [31:0] D1 = 32'hD111_1111;
    localparam logic [31:0] D2 = 32'hD222_2222;
    localparam logic [31:0] D3 = 32'hD333_3333;

    logic         HCLK;
    logic         HRESETn;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         HREADY;
    logic [31:0]  HRDATA;
    logic         HRESP;
    logic [3:0]   HSEL;
    logic [3:0]   HREADYOUT_S;
    logic [3:0]   HRESP_S;
    logic [127:0] HRDATA_S;
    logic         TIMEOUT_IRQ;

    int n_chk  = 0;
    int n_fail = 0;

    ahb_decoder_mux #(
        .NSLV      (4),
        .ADDR_BASE ({32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .ADDR_MASK ({32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000, 32'hFFFF_8000}),
        .TIMEOUT   (8)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HREADY      (HREADY),
        .HRDATA      (HRDATA),
        .HRESP       (HRESP),
        .HSEL        (HSEL),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA_S    (HRDATA_S),
        .TIMEOUT_IRQ (TIMEOUT_IRQ)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic rdy, input logic rsp, input logic irq);
        chk({tag, ".hready"}, {31'b0, HREADY}, {31'b0, rdy});
        chk({tag, ".hresp"},  {31'b0, HRESP},  {31'b0, rsp});
        chk({tag, ".irq"},    {31'b0, TIMEOUT_IRQ}, {31'b0, irq});
    endtask

    initial begin
        HRESETn     = 1'b0;
        HADDR       = 32'h0000_0010;
        HTRANS      = 2'b00;
        HREADYOUT_S = 4'hF;
        HRESP_S     = 4'h0;
        HRDATA_S    = {D3, D2, D1, D0};

        // Reset state
        #2;
        chk_rsp("reset", 1'b1, 1'b0, 1'b0);
        chk("reset.hrdata", HRDATA, 32'h0);
        chk("reset.hsel", {28'b0, HSEL}, 32'h1);
        cyc();
        cyc();
        HRESETn = 1'b1;

        // Decode boundaries and priority
        cyc();
        HADDR = 32'h0000_7FFC; #1;
        chk("dec.top_of_s0", {28'b0, HSEL}, 32'h1);
        HADDR = 32'h0000_8000; #1;
        chk("dec.past_s0", {28'b0, HSEL}, 32'h0);
        HADDR = 32'h2000_0100; #1;
        chk("dec.overlap_low_wins", {28'b0, HSEL}, 32'h4);
        HADDR = 32'h1ABC_0000; #1;
        chk("dec.s1", {28'b0, HSEL}, 32'h2);

        // Test 1: NONSEQ read to slave 0
        HADDR = 32'h0000_0010; HTRANS = 2'b10; #1;
        chk("t1.hsel", {28'b0, HSEL}, 32'h1);
        cyc();
        HTRANS = 2'b00; HADDR = 32'h0; #1;
        chk("t1.hrdata", HRDATA, D0);
        chk_rsp("t1", 1'b1, 1'b0, 1'b0);

        // Test 2: slave 2, three wait states; next address held off
        cyc();
        HADDR = 32'h2001_0000; HTRANS = 2'b10; HREADYOUT_S = 4'b1011; #1;
        chk("t2.hsel", {28'b0, HSEL}, 32'h4);
        cyc();
        HADDR = 32'h1000_0000; HTRANS = 2'b10; #1;
        chk_rsp("t2.w1", 1'b0, 1'b0, 1'b0);
        cyc();
        chk_rsp("t2.w2", 1'b0, 1'b0, 1'b0);
        cyc();
        chk_rsp("t2.w3", 1'b0, 1'b0, 1'b0);
        cyc();
        HREADYOUT_S = 4'hF; #1;
        chk_rsp("t2.done", 1'b1, 1'b0, 1'b0);
        chk("t2.hrdata", HRDATA, D2);
        cyc();
        HTRANS = 2'b00; #1;
        chk("t2.next_hrdata", HRDATA, D1);
        chk_rsp("t2.next", 1'b1, 1'b0, 1'b0);

        // Test 3: back-to-back unmapped accesses
        cyc();
        HADDR = 32'h5000_0000; HTRANS = 2'b10; #1;
        chk("t3.hsel", {28'b0, HSEL}, 32'h0);
        cyc();
        chk_rsp("t3.a.err1", 1'b0, 1'b1, 1'b0);
        chk("t3.a.hrdata", HRDATA, 32'h0);
        cyc();
        chk_rsp("t3.a.err2", 1'b1, 1'b1, 1'b0);
        cyc();
        chk_rsp("t3.b.err1", 1'b0, 1'b1, 1'b0);
        cyc();
        chk_rsp("t3.b.err2", 1'b1, 1'b1, 1'b0);
        HTRANS = 2'b00;
        cyc();
        chk_rsp("t3.after", 1'b1, 1'b0, 1'b0);

        // Test 4: IDLE and BUSY to unmapped address give no ERROR
        HADDR = 32'h5000_0000; HTRANS = 2'b00;
        cyc();
        chk_rsp("t4.idle", 1'b1, 1'b0, 1'b0);
        HTRANS = 2'b01;
        cyc();
        chk_rsp("t4.busy", 1'b1, 1'b0, 1'b0);

        // Test 5a: slave 1 stuck -> 8 waits, then two-cycle ERROR with IRQ
        HADDR = 32'h1000_0000; HTRANS = 2'b10; HREADYOUT_S = 4'b1101;
        cyc();
        HTRANS = 2'b00; #1;
        for (int i = 1; i <= 8; i++) begin
            chk_rsp($sformatf("t5a.w%0d", i), 1'b0, 1'b0, 1'b0);
            cyc();
        end
        chk_rsp("t5a.err1", 1'b0, 1'b1, 1'b1);
        chk("t5a.err1_hrdata", HRDATA, 32'h0);
        cyc();
        chk_rsp("t5a.err2", 1'b1, 1'b1, 1'b0);
        cyc();
        chk_rsp("t5a.after", 1'b1, 1'b0, 1'b0);

        // Test 5b: slave 1 released right as the count is reached -> OKAY
        HADDR = 32'h1000_0000; HTRANS = 2'b10;
        cyc();
        HTRANS = 2'b00; #1;
        for (int i = 1; i <= 8; i++) begin
            chk_rsp($sformatf("t5b.w%0d", i), 1'b0, 1'b0, 1'b0);
            cyc();
        end
        HREADYOUT_S = 4'hF; #1;
        chk_rsp("t5b.release", 1'b1, 1'b0, 1'b0);
        chk("t5b.hrdata", HRDATA, D1);
        cyc();
        chk_rsp("t5b.after", 1'b1, 1'b0, 1'b0);

        // Test 6: reset during a wait state
        HADDR = 32'h2000_0000; HTRANS = 2'b10; HREADYOUT_S = 4'b1011; HRESP_S = 4'b0100;
        cyc();
        HTRANS = 2'b00; #1;
        chk_rsp("t6.wait", 1'b0, 1'b1, 1'b0);
        HRESETn = 1'b0; #1;
        chk_rsp("t6.in_reset", 1'b1, 1'b0, 1'b0);
        chk("t6.in_reset_hrdata", HRDATA, 32'h0);
        cyc();
        HRESETn = 1'b1; HREADYOUT_S = 4'hF; HRESP_S = 4'h0;
        cyc();
        chk_rsp("t6.post_release", 1'b1, 1'b0, 1'b0);
        HADDR = 32'h2000_0000; HTRANS = 2'b10;
        cyc();
        HTRANS = 2'b00; #1;
        chk("t6.read_hrdata", HRDATA, D2);
        chk_rsp("t6.read", 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
